can_acf_multibank: RTL and testbench

Parametrised multi-bank acceptance filter for the SJA1000-compatible CAN controller. It sits between the bit-stream processor's frame-complete point and the RX FIFO write path. It generalises the fixed single/dual filter to NUM_FILTERS independently configured code/mask banks, each restricted to standard frames, extended frames or both. Banks are scanned sequentially, one per clock, and the scan reports the lowest-indexed matching bank.

---
 rtl/can_acf_multibank.sv | 140 ++++++++++++++
 tb/tb_can_acf_multibank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/can_acf_multibank.sv
// Multi-bank CAN acceptance filter: NUM_FILTERS code/mask banks scanned one per clock,
// the lowest-indexed matching bank wins.
module can_acf_multibank #(
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned IDX_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_all_i,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_index_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [29:0]      cfg_code_i,
  input  logic [29:0]      cfg_mask_i,
  output logic             cfg_busy_o,
  input  logic             frame_valid_i,
  input  logic [28:0]      frame_id_i,
  input  logic             frame_ide_i,
  input  logic             frame_rtr_i,
  output logic             result_valid_o,
  output logic             accept_o,
  output logic [IDX_W-1:0] hit_index_o,
  output logic             overrun_o,
  input  logic             overrun_clr_i
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_FILTERS - 1);
  // Standard frames only carry id[28:18]; id[17:0] sits at comparand bits [18:1].
  localparam logic [29:0]      StdMask = 30'h0007_FFFE;

  logic [1:0]       mode_q [NUM_FILTERS];
  logic [29:0]      code_q [NUM_FILTERS];
  logic [29:0]      mask_q [NUM_FILTERS];

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [28:0]      id_q;
  logic             ide_q;
  logic             rtr_q;
  logic             match_q;
  logic             result_valid_q;
  logic             accept_q;
  logic [IDX_W-1:0] hit_q;
  logic             overrun_q;

  logic             cfg_idx_ok;
  logic             bank_match;
  logic [29:0]      cmp_bits;

  assign cfg_idx_ok = 32'(cfg_index_i) < NUM_FILTERS;

  // Bank writes are only honoured while idle so a scan always sees a stable bank set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
        mode_q[k] <= 2'b00;
        code_q[k] <= 30'h0;
        mask_q[k] <= 30'h0;
      end
    end else if (cfg_we_i && (state_q == StIdle) && cfg_idx_ok) begin
      mode_q[cfg_index_i] <= cfg_mode_i;
      code_q[cfg_index_i] <= cfg_code_i;
      mask_q[cfg_index_i] <= cfg_mask_i;
    end
  end

  always_comb begin
    cmp_bits   = ~({id_q, rtr_q} ^ code_q[idx_q]) | mask_q[idx_q] |
                 (ide_q ? 30'h0 : StdMask);
    bank_match = (ide_q ? mode_q[idx_q][1] : mode_q[idx_q][0]) && (&cmp_bits);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      id_q           <= 29'h0;
      ide_q          <= 1'b0;
      rtr_q          <= 1'b0;
      match_q        <= 1'b0;
      result_valid_q <= 1'b0;
      accept_q       <= 1'b0;
      hit_q          <= '0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;

      if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end else if (frame_valid_i && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (frame_valid_i) begin
            id_q  <= frame_id_i;
            ide_q <= frame_ide_i;
            rtr_q <= frame_rtr_i;
            idx_q <= '0;
            if (accept_all_i) begin
              match_q <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StScan;
            end
          end
        end
        StScan: begin
          if (bank_match) begin
            match_q <= 1'b1;
            state_q <= StDone;
          end else if (idx_q == LastIdx) begin
            match_q <= 1'b0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // idx_q still holds the hit bank (or 0 for accept_all).
          result_valid_q <= 1'b1;
          accept_q       <= match_q;
          hit_q          <= match_q ? idx_q : '0;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_busy_o     = (state_q != StIdle);
  assign result_valid_o = result_valid_q;
  assign accept_o       = accept_q;
  assign hit_index_o    = hit_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_can_acf_multibank.sv
// Self-checking bench for can_acf_multibank: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a frame-level reference model.
module tb_can_acf_multibank;

  localparam int NF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        accept_all = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_index = 2'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [29:0] cfg_code = 30'h0;
  logic [29:0] cfg_mask = 30'h0;
  logic        fv = 1'b0;
  logic [28:0] fid = 29'h0;
  logic        fide = 1'b0;
  logic        frtr = 1'b0;
  logic        oclr = 1'b0;
  logic        cfg_busy, result_valid, accept, overrun;
  logic [1:0]  hit_index;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  can_acf_multibank #(.NUM_FILTERS(NF)) dut (
    .clk           (clk),
    .rst           (rst),
    .accept_all_i  (accept_all),
    .cfg_we_i      (cfg_we),
    .cfg_index_i   (cfg_index),
    .cfg_mode_i    (cfg_mode),
    .cfg_code_i    (cfg_code),
    .cfg_mask_i    (cfg_mask),
    .cfg_busy_o    (cfg_busy),
    .frame_valid_i (fv),
    .frame_id_i    (fid),
    .frame_ide_i   (fide),
    .frame_rtr_i   (frtr),
    .result_valid_o(result_valid),
    .accept_o      (accept),
    .hit_index_o   (hit_index),
    .overrun_o     (overrun),
    .overrun_clr_i (oclr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bank table plus one pending verdict with its due edge.
  logic [1:0]  m_mode [NF];
  logic [29:0] m_code [NF];
  logic [29:0] m_mask [NF];
  int ecyc = 0, idle_at = 0, due = 0, p_hit = 0, exp_hit = 0, m_h = 0, m_l = 0;
  bit pend = 0, p_acc = 0, exp_rv = 0, exp_acc = 0, exp_busy = 0, exp_ovr = 0;
  bit m_busy = 0, m_a = 0;

  function automatic void model_scan(input logic [28:0] id, input bit ide, input bit rtr,
                                     output bit acc, output int hit, output int lat);
    logic [29:0] care;
    bit kind_ok;
    acc = 0; hit = 0; lat = NF + 1;
    for (int k = 0; k < NF; k++) begin
      kind_ok = ide ? m_mode[k][1] : m_mode[k][0];
      care = ~m_mask[k];
      if (!ide) care[18:1] = 18'h0;
      if (!acc && kind_ok && ((({id, rtr} ^ m_code[k]) & care) == 30'h0)) begin
        acc = 1; hit = k; lat = k + 2;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NF; k++) begin
        m_mode[k] = 2'b00; m_code[k] = 30'h0; m_mask[k] = 30'h0;
      end
      idle_at = 0; pend = 0;
      exp_rv = 0; exp_acc = 0; exp_hit = 0; exp_busy = 0; exp_ovr = 0;
    end else begin
      ecyc++;
      m_busy = (ecyc <= idle_at);
      if (oclr) exp_ovr = 0;
      else if (fv && m_busy) exp_ovr = 1;
      if (cfg_we && !m_busy && int'(cfg_index) < NF) begin
        m_mode[cfg_index] = cfg_mode;
        m_code[cfg_index] = cfg_code;
        m_mask[cfg_index] = cfg_mask;
      end
      exp_rv = 0;
      if (pend && ecyc == due) begin
        exp_rv = 1; exp_acc = p_acc; exp_hit = p_hit; pend = 0;
      end
      if (fv && !m_busy) begin
        if (accept_all) begin m_a = 1; m_h = 0; m_l = 1; end
        else model_scan(fid, fide, frtr, m_a, m_h, m_l);
        pend = 1; due = ecyc + m_l; p_acc = m_a; p_hit = m_h; idle_at = ecyc + m_l;
      end
      exp_busy = (ecyc < idle_at);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("result_valid", 64'(result_valid), 64'(exp_rv));
      check("cfg_busy", 64'(cfg_busy), 64'(exp_busy));
      check("overrun", 64'(overrun), 64'(exp_ovr));
      check("accept", 64'(accept), 64'(exp_acc));
      check("hit_index", 64'(hit_index), 64'(exp_hit));
    end
  end

  task automatic cfg(input int idx, input logic [1:0] mode, input logic [29:0] code,
                     input logic [29:0] mask);
    cfg_we = 1; cfg_index = 2'(idx); cfg_mode = mode; cfg_code = code; cfg_mask = mask;
    @(negedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic send_and_check(input string name, input logic [28:0] id, input bit ide,
                                input bit rtr, input bit e_acc, input int e_hit,
                                input int e_lat);
    int lat;
    fid = id; fide = ide; frtr = rtr; fv = 1;
    @(negedge clk); #1;
    fv = 0;
    wait_result(lat);
    check({name, "_lat"}, 64'(lat), 64'(e_lat));
    check({name, "_acc"}, 64'(accept), 64'(e_acc));
    check({name, "_hit"}, 64'(hit_index), 64'(e_hit));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    int n, seen, b, sel;
    repeat (2) @(negedge clk);
    chk_en = 1;
    #1 rst = 0;
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_accept", 64'(accept), 64'd0);
    check("rst_hit", 64'(hit_index), 64'd0);
    check("rst_busy", 64'(cfg_busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    cfg(0, 2'b11, {11'h123, 18'h0, 1'b0}, 30'h0);
    send_and_check("std_b0", {11'h123, 18'h2A5A5}, 0, 0, 1, 0, 2);

    for (int k = 0; k < NF; k++) cfg(k, 2'b10, {29'(k + 1), 1'b0}, 30'h0);
    send_and_check("ext_b3", 29'h4, 1, 0, 1, 3, 5);
    send_and_check("ext_miss", 29'h5, 1, 0, 0, 0, 5);

    cfg(1, 2'b01, {29'h0ABCDEF, 1'b0}, 30'h3FFFFFFF);
    send_and_check("mode_ext", 29'h0ABCDEF, 1, 0, 0, 0, 5);
    send_and_check("mode_std", 29'h0ABCDEF, 0, 0, 1, 1, 3);

    cfg(2, 2'b11, {29'h0333333, 1'b0}, 30'h1);
    send_and_check("rtr_dc1", 29'h0333333, 1, 1, 1, 2, 4);
    send_and_check("rtr_dc0", 29'h0333333, 1, 0, 1, 2, 4);
    cfg(2, 2'b11, {29'h0333333, 1'b0}, 30'h0);
    send_and_check("rtr_care", 29'h0333333, 1, 1, 0, 0, 5);

    accept_all = 1;
    send_and_check("acc_all", 29'h1ABCDEF, 1, 0, 1, 0, 1);
    accept_all = 0;

    fid = 29'h0333333; fide = 1; frtr = 0; fv = 1;
    @(negedge clk); #1 fv = 0;
    @(negedge clk); #1 fv = 1;
    @(negedge clk); #1 fv = 0;
    check("ovr_set", 64'(overrun), 64'd1);
    wait_result(n);
    check("ovr_first_acc", 64'(accept), 64'd1);
    check("ovr_first_hit", 64'(hit_index), 64'd2);
    fv = 1;
    @(negedge clk); #1 fv = 0;
    @(negedge clk); #1 fv = 1; oclr = 1;
    @(negedge clk); #1 fv = 0; oclr = 0;
    check("ovr_clr", 64'(overrun), 64'd0);
    wait_result(n);
    check("ovr_third_acc", 64'(accept), 64'd1);

    fid = 29'h5; fide = 1; frtr = 0; fv = 1;
    @(negedge clk); #1 fv = 0;
    @(negedge clk); #1 rst = 1;
    #1;
    check("mid_rst_rv", 64'(result_valid), 64'd0);
    check("mid_rst_acc", 64'(accept), 64'd0);
    check("mid_rst_hit", 64'(hit_index), 64'd0);
    check("mid_rst_busy", 64'(cfg_busy), 64'd0);
    check("mid_rst_ovr", 64'(overrun), 64'd0);
    @(negedge clk); #1 rst = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (result_valid) seen++;
    end
    check("no_rv_after_rst", 64'(seen), 64'd0);

    fid = 29'h0777; fide = 1; frtr = 0; fv = 1;
    @(negedge clk); #1 fv = 0;
    cfg(0, 2'b11, {29'h0777, 1'b0}, 30'h0);
    wait_result(n);
    check("busy_cfg_scan_acc", 64'(accept), 64'd0);
    send_and_check("busy_cfg_ignored", 29'h0777, 1, 0, 0, 0, 5);

    for (int i = 0; i < 3000; i++) begin
      fv = ($urandom_range(0, 3) == 0);
      oclr = ($urandom_range(0, 15) == 0);
      accept_all = ($urandom_range(0, 7) == 0);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_index = 2'($urandom_range(0, NF - 1));
      cfg_mode = 2'($urandom);
      cfg_code = 30'($urandom);
      sel = $urandom_range(0, 3);
      cfg_mask = (sel == 0) ? 30'h0 : (sel == 1) ? 30'h3FFFFFFF :
                 (sel == 2) ? 30'($urandom) : (30'($urandom) & 30'hFF);
      b = $urandom_range(0, NF - 1);
      fid = m_code[b][29:1] ^ (29'($urandom) & m_mask[b][29:1]);
      if ($urandom_range(0, 3) == 0) fid = fid ^ (29'd1 << $urandom_range(0, 28));
      frtr = m_code[b][0] ^ ($urandom_range(0, 5) == 0);
      fide = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 999) == 0);
      @(negedge clk); #1;
    end
    fv = 0; oclr = 0; accept_all = 0; cfg_we = 0; rst = 0;
    repeat (10) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
